// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter
//
// Round-robin, burst-locking arbiter that shares one fifo enqueue port
// among NUM_REQ producers. The selected producer is forwarded to the fifo
// in the same cycle; every beat is tagged with its source index so the
// consumer side can demultiplex. Once a producer wins, it keeps the grant
// for up to MAX_BURST accepted beats, so each source's run stays contiguous.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   req_valid  per-requester valid
//   req_data   requester i occupies bits [i*WIDTH +: WIDTH]
//   req_ready  per-requester ready, at most one bit high
//   enq_valid  to fifo enq_valid
//   enq_data   to fifo enq_data
//   enq_id     source index of the current beat
//   enq_ready  from fifo enq_ready
module fifo_enq_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       enq_valid,
    output logic [WIDTH-1:0]           enq_data,
    output logic [IDW-1:0]             enq_id,
    input  logic                       enq_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    owner, owner_nxt;
    logic [IDW-1:0]    ptr, ptr_nxt;
    logic [CW-1:0]     beat_cnt, beat_cnt_nxt;

    logic [IDW-1:0]    sel;
    logic              any_valid;
    logic [IDW-1:0]    cur;
    logic              cur_valid;
    logic [WIDTH-1:0]  cur_data;
    logic              active;
    logic              xfer;

    logic [2*NUM_REQ-1:0] valid_rot;

    // Index after idx, wrapping from NUM_REQ-1 back to 0.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Rotate the valid vector so bit 0 is the highest-priority requester,
    // then take the first set bit and map it back to an absolute index.
    always_comb begin
        int s;
        valid_rot = {req_valid, req_valid} >> ptr;
        sel       = '0;
        any_valid = 1'b0;
        s         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && valid_rot[k]) begin
                any_valid = 1'b1;
                s         = int'(ptr) + k;
                if (s >= NUM_REQ) begin
                    s = s - NUM_REQ;
                end
                sel = IDW'(s);
            end
        end
    end

    // While locked only the owner is forwarded; while idle the round-robin
    // winner is. Outputs are forced quiet whenever reset is held.
    always_comb begin
        cur       = (state == LOCKED) ? owner : sel;
        active    = (state == LOCKED) || any_valid;
        cur_valid = 1'b0;
        cur_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (cur == IDW'(j)) begin
                cur_valid = req_valid[j];
                cur_data  = req_data[j*WIDTH +: WIDTH];
            end
        end

        enq_valid = active && cur_valid && rst;
        enq_data  = active ? cur_data : '0;
        enq_id    = active ? cur : '0;

        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (active && rst && (cur == IDW'(j))) begin
                req_ready[j] = enq_ready;
            end
        end

        xfer = enq_valid && enq_ready;
    end

    // Grant bookkeeping. Locking on a stalled first beat keeps the forwarded
    // beat stable under backpressure; a dropped owner valid costs one bubble.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    if (xfer && (MAX_BURST == 1)) begin
                        ptr_nxt = next_idx(sel);
                    end else begin
                        state_nxt    = LOCKED;
                        owner_nxt    = sel;
                        beat_cnt_nxt = xfer ? CW'(1) : '0;
                    end
                end
            end
            LOCKED: begin
                if (!cur_valid) begin
                    state_nxt    = IDLE;
                    ptr_nxt      = next_idx(owner);
                    beat_cnt_nxt = '0;
                end else if (xfer) begin
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        state_nxt    = IDLE;
                        ptr_nxt      = next_idx(owner);
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Testbench for fifo_enq_arbiter: directed scenarios plus randomized traffic
// compared against a grant/credit reference model, and an end-to-end run
// through a behavioural bounded fifo.
module tb_fifo_enq_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int IDW       = 2;
    localparam int MAX_BURST = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     enq_valid;
    logic [WIDTH-1:0]         enq_data;
    logic [IDW-1:0]           enq_id;
    logic                     enq_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: a holder with a credit budget and a rotating priority.
    int                 m_holder = -1;
    int                 m_credits = 0;
    int                 m_prio = 0;
    int                 exp_src;
    logic               exp_valid;
    logic [WIDTH-1:0]   exp_data;
    int                 exp_id;
    logic [NUM_REQ-1:0] exp_ready;

    always #5 clk = ~clk;

    fifo_enq_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_id(enq_id),
        .enq_ready(enq_ready)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [WIDTH-1:0] data_of(int i);
        return req_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        m_holder  = -1;
        m_credits = 0;
        m_prio    = 0;
    endtask

    task automatic model_eval();
        int i;
        exp_src = -1;
        if (m_holder >= 0) begin
            exp_src = m_holder;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_prio + k) % NUM_REQ;
                if (exp_src < 0 && req_valid[i]) exp_src = i;
            end
        end
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_id    = 0;
        exp_ready = '0;
        if (exp_src >= 0) begin
            exp_valid          = req_valid[exp_src];
            exp_data           = data_of(exp_src);
            exp_id             = exp_src;
            exp_ready[exp_src] = enq_ready;
        end
    endtask

    task automatic model_release();
        m_prio   = (m_holder + 1) % NUM_REQ;
        m_holder = -1;
    endtask

    task automatic model_step();
        bit accepted;
        accepted = exp_valid && enq_ready;
        if (m_holder < 0 && exp_src >= 0) begin
            m_holder  = exp_src;
            m_credits = MAX_BURST;
        end
        if (m_holder >= 0) begin
            if (!req_valid[m_holder]) begin
                model_release();
            end else if (accepted) begin
                m_credits--;
                if (m_credits == 0) model_release();
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        enq_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        enq_ready = 1'b1;
        #3;
        checks++;
        if (enq_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_quiet: enq_valid=%b req_ready=%b, want 0 and 0000", enq_valid, req_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd0 || enq_data !== 32'h1) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: v=%b id=%0d data=%h, want 1 0 00000001", enq_valid, enq_id, enq_data);
        end
        adv();
        do_reset();
    endtask

    task automatic test_single_source();
        logic [WIDTH-1:0] want;
        do_reset();
        enq_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            want = WIDTH'(32'h100 + b);
            req_valid = 4'b0100;
            req_data[2*WIDTH +: WIDTH] = want;
            settle();
            checks++;
            if (enq_valid !== 1'b1 || enq_id !== 2'd2 || enq_data !== want) begin
                errors++;
                $display("[TB] FAIL single_beat%0d: v=%b id=%0d data=%h, want 1 2 %h", b, enq_valid, enq_id, enq_data, want);
            end
            checks++;
            if (req_ready !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL single_ready%0d: req_ready=%b, want 0100", b, req_ready);
            end
            adv();
        end
        req_valid = '0;
        settle();
        checks++;
        if (enq_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drop: enq_valid=%b, want 0", enq_valid);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        int cnt [NUM_REQ];
        int id_want;
        logic [WIDTH-1:0] want;
        do_reset();
        enq_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = '1;
            for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(i * 256 + cnt[i]);
            id_want = (c / MAX_BURST) % NUM_REQ;
            want    = WIDTH'(id_want * 256 + cnt[id_want]);
            settle();
            checks++;
            if (enq_valid !== 1'b1 || enq_id !== IDW'(id_want) || enq_data !== want) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: v=%b id=%0d data=%h, want 1 %0d %h", c, enq_valid, enq_id, enq_data, id_want, want);
            end
            cnt[id_want]++;
            adv();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            enq_ready = 1'b0;
            req_valid = (c >= 2) ? 4'b0011 : 4'b0010;
            req_data[0 +: WIDTH]     = 32'h55;
            req_data[WIDTH +: WIDTH] = 32'hAA;
            settle();
            checks++;
            if (enq_valid !== 1'b1 || enq_id !== 2'd1 || enq_data !== 32'hAA || req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: v=%b id=%0d data=%h rdy=%b, want 1 1 000000aa 0000", c, enq_valid, enq_id, enq_data, req_ready);
            end
            adv();
        end
        enq_ready = 1'b1;
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd1 || enq_data !== 32'hAA || req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL stall_release: v=%b id=%0d data=%h rdy=%b, want 1 1 000000aa 0010", enq_valid, enq_id, enq_data, req_ready);
        end
        adv();
        req_data[WIDTH +: WIDTH] = 32'hAB;
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd1 || enq_data !== 32'hAB) begin
            errors++;
            $display("[TB] FAIL stall_continue: v=%b id=%0d data=%h, want 1 1 000000ab", enq_valid, enq_id, enq_data);
        end
        adv();
        req_valid = 4'b0001;
        settle();
        checks++;
        if (enq_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_bubble: enq_valid=%b, want 0", enq_valid);
        end
        adv();
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd0 || enq_data !== 32'h55 || req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL stall_next_owner: v=%b id=%0d data=%h rdy=%b, want 1 0 00000055 0001", enq_valid, enq_id, enq_data, req_ready);
        end
        adv();
        req_valid = '0;
    endtask

    task automatic test_drop_bubble();
        do_reset();
        enq_ready = 1'b1;
        req_valid = 4'b1000;
        req_data[3*WIDTH +: WIDTH] = 32'h300;
        settle();
        adv();
        req_valid = 4'b1001;
        req_data[3*WIDTH +: WIDTH] = 32'h301;
        req_data[0 +: WIDTH]       = 32'h11;
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd3 || enq_data !== 32'h301) begin
            errors++;
            $display("[TB] FAIL drop_locked: v=%b id=%0d data=%h, want 1 3 00000301", enq_valid, enq_id, enq_data);
        end
        adv();
        req_valid = 4'b0001;
        settle();
        checks++;
        if (enq_valid !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_bubble: v=%b rdy=%b, want 0 and bit0 clear", enq_valid, req_ready);
        end
        adv();
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd0 || enq_data !== 32'h11) begin
            errors++;
            $display("[TB] FAIL drop_wrap: v=%b id=%0d data=%h, want 1 0 00000011", enq_valid, enq_id, enq_data);
        end
        adv();
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        enq_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            req_valid = 4'b0010;
            req_data[WIDTH +: WIDTH] = WIDTH'(32'h10 + b);
            settle();
            adv();
        end
        req_valid = 4'b0110;
        req_data[WIDTH +: WIDTH]   = 32'h12;
        req_data[2*WIDTH +: WIDTH] = 32'h20;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (enq_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset: v=%b rdy=%b, want 0 and 0000", enq_valid, req_ready);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        settle();
        checks++;
        if (enq_valid !== 1'b1 || enq_id !== 2'd1 || enq_data !== 32'h12) begin
            errors++;
            $display("[TB] FAIL async_regrant: v=%b id=%0d data=%h, want 1 1 00000012", enq_valid, enq_id, enq_data);
        end
        adv();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0]       nv;
        logic [NUM_REQ*WIDTH-1:0] nd;
        logic                     nr;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            settle();
            checks++;
            if (enq_valid !== exp_valid || enq_id !== IDW'(exp_id) || enq_data !== exp_data || req_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: v=%b id=%0d data=%h rdy=%b, want %b %0d %h %b", c, enq_valid, enq_id, enq_data, req_ready, exp_valid, exp_id, exp_data, exp_ready);
            end
            nv = req_valid;
            nd = req_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_valid[i] && !exp_ready[i])) begin
                    nv[i] = ($urandom_range(0, 2) != 0);
                    nd[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            nr = ($urandom_range(0, 3) != 0);
            adv();
            req_valid = nv;
            req_data  = nd;
            enq_ready = nr;
        end
        req_valid = '0;
    endtask

    task automatic test_fifo_drain();
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] v;
        int next_i [NUM_REQ];
        int pop_i  [NUM_REQ];
        int popped, delay, xs, nsel, id;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            next_i[i] = 0;
            pop_i[i]  = 0;
        end
        popped = 0;
        delay  = 0;
        for (int c = 0; c < 3000 && popped < 200; c++) begin
            enq_ready = (q.size() < 8);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (next_i[i] < 50);
                req_data[i*WIDTH +: WIDTH] = WIDTH'(i * 1000 + next_i[i]);
            end
            settle();
            xs   = -1;
            nsel = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] === 1'b1) begin
                    xs = i;
                    nsel++;
                end
            end
            if (enq_valid === 1'b1 && enq_ready) begin
                checks++;
                if (nsel != 1 || xs < 0 || enq_id !== IDW'(xs) || enq_data !== WIDTH'(xs * 1000 + next_i[xs])) begin
                    errors++;
                    $display("[TB] FAIL fifo_push: id=%0d data=%h acks=%0d src=%0d, want one ack matching id and data", enq_id, enq_data, nsel, xs);
                end
                q.push_back(enq_data);
            end
            if (xs >= 0) next_i[xs]++;
            if (delay == 0 && q.size() > 0) begin
                v  = q.pop_front();
                id = int'(v) / 1000;
                checks++;
                if (id >= NUM_REQ || int'(v) % 1000 != pop_i[id]) begin
                    errors++;
                    $display("[TB] FAIL fifo_order: popped %0d, want item %0d of that source", v, (id < NUM_REQ) ? pop_i[id] : -1);
                end
                if (id < NUM_REQ) pop_i[id] = int'(v) % 1000 + 1;
                popped++;
                delay = $urandom_range(0, 3);
            end else if (delay > 0) begin
                delay--;
            end
            adv();
        end
        checks++;
        if (popped != 200) begin
            errors++;
            $display("[TB] FAIL fifo_total: dequeued %0d, want 200", popped);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_back_to_back();
        test_backpressure();
        test_drop_bubble();
        test_async_reset();
        test_random();
        test_fifo_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_enq_arbiter.md
Name: fifo_enq_arbiter

Overview:
- Round-robin, burst-locking arbiter that shares one FIFO enqueue port among NUM_REQ producers.
- Sits directly in front of the team's valid/ready fifo: its enq_* outputs drive fifo enq_valid/enq_data, and it takes fifo enq_ready as input.
- Tags every beat with the source index so consumers can demultiplex.
- Zero-latency forwarding; grant held for up to MAX_BURST accepted beats to keep per-source runs contiguous.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 32, data width per beat.
- IDW, 2, width of source ID; must satisfy 2**IDW >= NUM_REQ.
- MAX_BURST, 4, max accepted beats per grant (>=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  per-requester ready; at most one bit high.
- enq_valid  output  1  to fifo enq_valid.
- enq_data  output  WIDTH  to fifo enq_data.
- enq_id  output  IDW  source index of current beat.
- enq_ready  input  1  from fifo enq_ready.

Behaviour:
- State: fsm {IDLE, LOCKED}, owner[IDW], ptr[IDW] (highest-priority index), beat_cnt (clog2(MAX_BURST+1) bits).
- Reset (rst low, async): fsm=IDLE, ptr=0, owner=0, beat_cnt=0. While rst is low, enq_valid=0 and req_ready=0, regardless of inputs.
- Transfer on a requester side: req_valid[i] && req_ready[i]. Transfer on the fifo side: enq_valid && enq_ready. The two always coincide for the granted index.
- Protocol contract on requesters: once req_valid[i] is high, hold it and the data stable until the transfer. The arbiter relies on this.

IDLE:
- sel = first i with req_valid[i], scanning ptr, ptr+1, ... mod NUM_REQ.
- Outputs are combinational, same cycle: enq_valid=req_valid[sel], enq_data=req_data[sel], enq_id=sel, req_ready[sel]=enq_ready, all other req_ready=0.
- No valid request: enq_valid=0, enq_id=0, enq_data=0, req_ready=0.
- Valid present, transfer occurs, and MAX_BURST==1: stay IDLE, ptr<=sel+1 mod NUM_REQ.
- Valid present otherwise: ->LOCKED, owner<=sel, beat_cnt<=(transfer?1:0).
- Locking without a transfer keeps enq_valid/enq_data/enq_id stable under backpressure.

LOCKED:
- Outputs forward owner only: enq_valid=req_valid[owner], enq_data=req_data[owner], enq_id=owner, req_ready[owner]=enq_ready.
- Transfer with beat_cnt+1==MAX_BURST: ->IDLE, ptr<=owner+1, beat_cnt<=0. The next cycle arbitrates immediately, so there is no bubble.
- Transfer otherwise: beat_cnt<=beat_cnt+1.
- req_valid[owner]==0 (possible only after at least one beat): that cycle has enq_valid=0 (one bubble); ->IDLE, ptr<=owner+1.

Boundary rules:
- ptr wrap: from NUM_REQ-1 back to 0.
- Requests from non-owners are ignored while LOCKED, even if higher priority.
- Sustained enq_ready=0 (fifo full): owner, beat_cnt, outputs frozen; no starvation by timeout.
- Reset mid-burst: burst abandoned and ptr returns to 0. The fifo contents are not the arbiter's responsibility.
- Throughput: with every requester continuously valid and enq_ready=1, one beat per cycle indefinitely.

Test Plan:
- Only r2 valid, data 0x100,0x101,0x102, enq_ready=1 -> three consecutive enq beats, enq_id=2, data in order, req_ready[2] high same cycles, req_ready[0,1,3]=0.
- All four valid continuously, MAX_BURST=4, enq_ready=1 -> enq_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... with 16 beats in 16 cycles and no bubble.
- r1 presents 0xAA with enq_ready=0 for 5 cycles; r0 asserts at cycle 2:
  - enq_valid=1, enq_data=0xAA, enq_id=1 stable throughout; req_ready[0]=0.
  - When enq_ready rises, 0xAA is accepted, then r1 continues its burst.
- r3 sends 2 beats then drops valid, r0 valid waiting -> one cycle enq_valid=0, next cycle r0 granted (ptr wrapped 3->0).
- r1 locked after 2 of 4 beats; assert rst low asynchronously between edges:
  - enq_valid=0 and req_ready=0 immediately.
  - After release, with r1 and r2 valid, r1 is granted first (ptr=0, r0 idle).
- Arbiter + fifo (WIDTH 32, LOGDEPTH 3): 4 requesters × 50 items each, value id*1000+i; fifo drained with read delays 0..3 -> 200 items dequeued, per-id order preserved, none lost or duplicated, enq_id matches value/1000.
